// File: rtl/packet_source_tx.sv
// Packet channel transmitter: buffers producer words in a small FIFO, wraps
// each one in a header and drives it over a four-phase bundled-data link.
module packet_source_tx #(
    parameter int unsigned DWIDTH   = 8,
    parameter int unsigned PWIDTH   = 47,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned SEQ_W    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ACK_SYNC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] src_id,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic [ADDR_W-1:0] in_dest,
    output logic              pkt_req,
    input  logic              pkt_ack,
    output logic [PWIDTH-1:0] pkt_data,
    output logic [15:0]       sent_count,
    output logic              busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = DWIDTH + ADDR_W;
    localparam int unsigned HDR_W = DWIDTH + SEQ_W + 2 * ADDR_W;

    // Reject parameter sets the packet layout or FIFO cannot support
    if (PWIDTH < HDR_W) begin : g_bad_pwidth
        $error("packet_source_tx: PWIDTH too small for header + data");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("packet_source_tx: DEPTH must be a power of 2 and >= 2");
    end
    if (ACK_SYNC > 3) begin : g_bad_sync
        $error("packet_source_tx: ACK_SYNC must be 0..3");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt_c;
    logic               ack_s;

    logic [ENT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt_c;
    logic               push_c;
    logic               pop_c;
    logic [DWIDTH-1:0]  head_data_c;
    logic [ADDR_W-1:0]  head_dest_c;
    logic [SEQ_W-1:0]   seq;

    // Acknowledge synchronizer (bypassed when ACK_SYNC is 0)
    if (ACK_SYNC == 0) begin : g_no_sync
        assign ack_s = pkt_ack;
    end else begin : g_sync
        logic [ACK_SYNC-1:0] sync_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= ACK_SYNC'({sync_q, pkt_ack});
            end
        end
        assign ack_s = sync_q[ACK_SYNC-1];
    end

    // FIFO handshake decode, occupancy and FSM next state
    always_comb begin
        push_c      = in_valid & in_ready;
        pop_c       = (state == ST_IDLE) && (count != '0) && !ack_s;
        count_nxt_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
        {head_dest_c, head_data_c} = mem[rd_ptr];
        state_nxt_c = state;
        case (state)
            ST_IDLE:     if (pop_c)  state_nxt_c = ST_REQ;
            ST_REQ:      if (ack_s)  state_nxt_c = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!ack_s) state_nxt_c = ST_IDLE;
            default:                 state_nxt_c = ST_IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care while the entry is unoccupied
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= {in_dest, in_data};
        end
    end

    // FIFO pointers, occupancy and registered ready/busy status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_nxt_c;
            in_ready <= (count_nxt_c != CNT_W'(DEPTH));
            busy     <= (count_nxt_c != '0) || (state_nxt_c != ST_IDLE);
        end
    end

    // Four-phase handshake FSM with registered req, packet and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pkt_req    <= 1'b0;
            pkt_data   <= '0;
            seq        <= '0;
            sent_count <= '0;
        end else begin
            state <= state_nxt_c;
            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        pkt_data <= PWIDTH'({head_dest_c, src_id, seq, head_data_c});
                        pkt_req  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ack_s) pkt_req <= 1'b0;
                end
                ST_WAIT_LOW: begin
                    if (!ack_s) begin
                        seq        <= seq + SEQ_W'(1);
                        sent_count <= sent_count + 16'd1;
                    end
                end
                default: pkt_req <= 1'b0;
            endcase
        end
    end

endmodule
